// File: rtl/i2c_pkg.sv
// Shared types for the I2C byte controller: opcodes, FSM states, bit counts.
package i2c_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_STOP  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  localparam logic [3:0] BYTE_LAST = 4'd8;
  localparam logic [3:0] COND_LAST = 4'd0;
  localparam logic [1:0] Q_SAMPLE  = 2'd2;
  localparam logic [1:0] Q_LAST    = 2'd3;

  function automatic state_e op_state(input op_e op);
    state_e s;
    s = ST_IDLE;
    unique case (op)
      OP_START: s = ST_START;
      OP_WRITE: s = ST_WRITE;
      OP_READ:  s = ST_READ;
      OP_STOP:  s = ST_STOP;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] last_bit(input state_e s);
    return (s == ST_WRITE || s == ST_READ) ? BYTE_LAST : COND_LAST;
  endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-bit timebase: counts QTR cycles while enabled, freezes on stall,
// and pulses tick on the last cycle of each quarter.
module i2c_qtr_tick #(
  parameter int QTR = 62
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic stall,
  output logic tick
);

  localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0] LAST = CW'(QTR - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en) begin
      cnt_q <= '0;
    end else if (!stall) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && !stall && (cnt_q == LAST);

endmodule

// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master: START / WRITE / READ / STOP on open-drain lines.
// Define I2C_CLK_STRETCH_EN to let a slave holding SCL low stall the timebase.
module i2c_byte_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int I2C_FREQ = 400_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_ack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int QTR = CLK_FREQ / (4 * I2C_FREQ);

  state_e     state_q, state_d;
  logic [1:0] q_q;
  logic [3:0] bit_q;
  logic [7:0] dat_q;
  logic       ack_q;
  logic [7:0] shf_q;
  logic       nck_q;
  logic       scl_q, sda_q;
  logic       scl_d, sda_d;
  logic       tick, stall, accept, done;
  logic       is_start, is_write, is_read, is_stop;
  logic [3:0] lb;
  logic [2:0] idx;

  assign is_start = (state_q == ST_START);
  assign is_write = (state_q == ST_WRITE);
  assign is_read  = (state_q == ST_READ);
  assign is_stop  = (state_q == ST_STOP);

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign lb        = last_bit(state_q);
  assign done      = tick && (q_q == Q_LAST) && (bit_q == lb);
  assign idx       = 3'(4'd7 - bit_q);

`ifdef I2C_CLK_STRETCH_EN
  assign stall = scl_q && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign stall = 1'b0;
`endif

  i2c_qtr_tick #(
    .QTR (QTR)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!cmd_ready),
    .stall (stall),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (cmd_valid) state_d = op_state(op_e'(cmd_op));
    end else if (done) begin
      state_d = ST_IDLE;
    end
  end

  // Line levels for the current quarter; IDLE holds the last levels.
  always_comb begin
    scl_d = scl_q;
    sda_d = sda_q;
    unique case (1'b1)
      is_start: begin
        scl_d = (q_q < 2'd2);
        sda_d = (q_q == 2'd0);
      end
      is_stop: begin
        scl_d = (q_q != 2'd0);
        sda_d = (q_q >= 2'd2);
      end
      is_write: begin
        scl_d = (q_q == 2'd1) || (q_q == 2'd2);
        sda_d = (bit_q == BYTE_LAST) ? 1'b1 : dat_q[idx];
      end
      is_read: begin
        scl_d = (q_q == 2'd1) || (q_q == 2'd2);
        sda_d = (bit_q == BYTE_LAST) ? ack_q : 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= '0;
      bit_q     <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      shf_q     <= '0;
      nck_q     <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_nack  <= 1'b0;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
      if (accept) begin
        dat_q <= cmd_data;
        ack_q <= cmd_ack;
      end
      if (tick) begin
        q_q <= q_q + 2'd1;
        if (q_q == Q_LAST)
          bit_q <= (bit_q == lb) ? 4'd0 : bit_q + 4'd1;
      end
      if (tick && q_q == Q_SAMPLE) begin
        if (is_read && bit_q != BYTE_LAST)
          shf_q <= {shf_q[6:0], sda_i};
        if (is_write && bit_q == BYTE_LAST)
          nck_q <= sda_i;
      end
      rsp_valid <= done && (is_write || is_read);
      if (done && is_write) rsp_nack <= nck_q;
      if (done && is_read)  rsp_data <= shf_q;
    end
  end

  assign scl_o = scl_q;
  assign sda_o = sda_q;

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Randomized scoreboard bench for i2c_byte_ctrl with a bus-level slave model.
module tb_i2c_byte_ctrl;

  localparam int QTR = 62;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ack = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_nack, busy;
  logic [7:0] rsp_data;
  logic       scl_o, sda_o, scl_i, sda_i;
  logic       slave_sda = 1'b1;
  logic       scl_hold = 1'b1;

  assign scl_i = scl_o & scl_hold;
  assign sda_i = sda_o & slave_sda;

  always #5 clk = ~clk;

  i2c_byte_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_ack   (cmd_ack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_nack  (rsp_nack),
    .busy      (busy),
    .scl_o     (scl_o),
    .sda_o     (sda_o),
    .scl_i     (scl_i),
    .sda_i     (sda_i)
  );

  typedef struct {
    logic [7:0] data;
    logic       nack;
    int         acc;
    int         lat;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  logic [7:0] m_data = 8'h00;
  logic       m_nack = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;
  int         n_rsp = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && rsp_valid) begin
      n_rsp++;
      if (sbq.size() == 0) begin
        chk("unexpected_rsp_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, mon_e.data});
        chk("rsp_nack", {31'd0, rsp_nack}, {31'd0, mon_e.nack});
        chk("rsp_latency", cyc - mon_e.acc, mon_e.lat);
        chk("ready_with_rsp", {31'd0, cmd_ready}, 32'd1);
      end
    end
  end

  task automatic wait_scl(input logic lvl, output bit ok);
    logic prev;
    prev = scl_o;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (scl_o === lvl && prev !== lvl) begin
        ok = 1'b1;
        return;
      end
      prev = scl_o;
    end
    chk("scl_edge_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] d,
                       input logic a, output int acc);
    chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    cmd_ack = a;
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_data = 8'($urandom);
    cmd_ack = 1'($urandom);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] d,
                        input logic a, input logic [7:0] sbyte,
                        input logic snack, input bit stretch);
    int acc, lat;
    bit ok, seen;
    logic [7:0] cap;
    logic prev_sda;
    issue(op, d, a, acc);
    lat = (op == 2'd1 || op == 2'd2) ? 36 * QTR : 4 * QTR;
`ifdef I2C_CLK_STRETCH_EN
    if (stretch) lat += 100;
`endif
    if (op == 2'd1) m_nack = snack;
    if (op == 2'd2) m_data = sbyte;
    if (op == 2'd1 || op == 2'd2)
      sbq.push_back('{data: m_data, nack: m_nack, acc: acc, lat: lat});
    if (op == 2'd1) begin
      cap = 8'h00;
      for (int i = 0; i < 9; i++) begin
        wait_scl(1'b1, ok);
        if (!ok) break;
        if (i < 8) cap = {cap[6:0], sda_o};
        else chk("wr_ack_released", {31'd0, sda_o}, 32'd1);
        if (stretch && i == 2) begin
          scl_hold = 1'b0;
          repeat (100) @(posedge clk);
          #1;
          scl_hold = 1'b1;
        end
        wait_scl(1'b0, ok);
        if (!ok) break;
        if (i == 7) slave_sda = snack;
        if (i == 8) slave_sda = 1'b1;
      end
      chk("wr_sda_bits", {24'd0, cap}, {24'd0, d});
    end else if (op == 2'd2) begin
      slave_sda = sbyte[7];
      for (int i = 0; i < 9; i++) begin
        wait_scl(1'b1, ok);
        if (!ok) break;
        if (i < 8) chk("rd_sda_released", {31'd0, sda_o}, 32'd1);
        else chk("rd_ack_bit", {31'd0, sda_o}, {31'd0, a});
        wait_scl(1'b0, ok);
        if (!ok) break;
        if (i < 7) slave_sda = sbyte[6-i];
        else slave_sda = 1'b1;
      end
    end
    slave_sda = 1'b1;
    seen = 1'b0;
    prev_sda = sda_o;
    for (int k = 0; k < 6000 && !cmd_ready; k++) begin
      @(posedge clk);
      #1;
      if (op == 2'd0 && prev_sda && !sda_o && scl_o) seen = 1'b1;
      if (op == 2'd3 && !prev_sda && sda_o && scl_o) seen = 1'b1;
      prev_sda = sda_o;
    end
    chk("busy_cycles", cyc - acc, lat);
    chk("busy_low_idle", {31'd0, busy}, 32'd0);
    if (op == 2'd0 || op == 2'd3) begin
      chk("bus_condition", {31'd0, seen}, 32'd1);
      chk("no_rsp_start_stop", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_scl"}, {31'd0, scl_o}, 32'd1);
    chk({tag, "_sda"}, {31'd0, sda_o}, 32'd1);
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"}, {24'd0, rsp_data}, 32'd0);
    chk({tag, "_rsp_nack"}, {31'd0, rsp_nack}, 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rsp_before;
    bit ok;
    logic [1:0] op;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_cmd(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    do_cmd(2'd1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
    do_cmd(2'd1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b0);
    do_cmd(2'd2, 8'h00, 1'b1, 8'h96, 1'b0, 1'b0);
    do_cmd(2'd3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    do_cmd(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    do_cmd(2'd1, 8'($urandom), 1'b0, 8'h00, 1'($urandom), 1'b1);

    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3));
      do_cmd(op, 8'($urandom), 1'($urandom), 8'($urandom),
             1'($urandom), 1'b0);
    end
    do_cmd(2'd3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    issue(2'd1, 8'h00, 1'b0, acc);
    for (int i = 0; i < 4; i++) begin
      wait_scl(1'b1, ok);
      wait_scl(1'b0, ok);
    end
    wait_scl(1'b1, ok);
    repeat (10) @(posedge clk);
    #1;
    rsp_before = n_rsp;
    rst_n = 1'b0;
    #1;
    m_data = 8'h00;
    m_nack = 1'b0;
    reset_checks("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3000) @(posedge clk);
    #1;
    chk("abort_no_rsp", n_rsp - rsp_before, 32'd0);

    do_cmd(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    do_cmd(2'd1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    do_cmd(2'd3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_byte_ctrl.md
I2C_BYTE_CTRL -- requirements
Module: i2c_byte_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter I2C_FREQ, default 400_000, SCL frequency in Hz.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_op  input  2  opcode: 0 START, 1 WRITE, 2 READ, 3 STOP.
REQ-008 cmd_data  input  8  byte to send on WRITE.
REQ-009 cmd_ack  input  1  ACK bit driven after READ (0 = ACK, 1 = NACK).
REQ-010 rsp_valid  output  1  one-cycle pulse, WRITE/READ complete.
REQ-011 rsp_data  output  8  byte received by READ.
REQ-012 rsp_nack  output  1  ACK bit sampled after WRITE (1 = NACK).
REQ-013 busy  output  1  command in progress.
REQ-014 scl_o, sda_o  output  1 each  open-drain controls: 0 = drive low, 1 = release.
REQ-015 scl_i, sda_i  input  1 each  sampled bus levels.

Function
REQ-016 Quarter period QTR = CLK_FREQ/(4*I2C_FREQ) cycles (62 at defaults); every bit occupies 4 quarters Q0..Q3.
REQ-017 States: IDLE, START, WRITE, READ, STOP; IDLE -> op state on cmd_valid && cmd_ready; op state -> IDLE after its last quarter.
REQ-018 cmd_ready = 1 only in IDLE; busy = !cmd_ready; cmd_op, cmd_data, cmd_ack latched on acceptance; inputs ignored otherwise.
REQ-019 START (1 bit): Q0 SDA release, SCL release; Q1 SDA low; Q2 SCL low; Q3 hold; usable as repeated START.
REQ-020 WRITE (9 bits): bits 8..1 drive cmd_data MSB first; SDA changes only at Q0 with SCL low; SCL released Q1-Q2, low Q0 and Q3.
REQ-021 WRITE bit 9: SDA released, sda_i sampled at end of Q2 into rsp_nack.
REQ-022 READ (9 bits): SDA released bits 1..8, sda_i sampled at end of Q2, shifted into rsp_data MSB first; bit 9 drives latched cmd_ack.
REQ-023 STOP (1 bit): Q0 SDA low, SCL low; Q1 SCL release; Q2 SDA release; Q3 hold.
REQ-024 Latency from acceptance: START/STOP 4*QTR cycles, WRITE/READ 36*QTR cycles, before returning to IDLE.
REQ-025 rsp_valid pulses exactly one cycle, the first IDLE cycle after WRITE/READ; cmd_ready high in that same cycle; no pulse for START/STOP.
REQ-026 rsp_data, rsp_nack hold until next WRITE/READ completes; READ leaves rsp_nack, WRITE leaves rsp_data unchanged.
REQ-027 Back-to-back: command accepted in rsp_valid cycle starts next cycle; bus lines hold last state while IDLE.
REQ-028 No bus-state checks: WRITE/READ without prior START and STOP from IDLE execute as specified.
REQ-029 Quarter counter wraps QTR-1 -> 0; bit counter wraps after final bit of op.

Reset
REQ-030 During/after reset: state IDLE, scl_o = sda_o = 1, cmd_ready = 1, busy = 0, rsp_valid = 0, rsp_data = 0x00, rsp_nack = 0, counters 0.
REQ-031 Reset mid-operation aborts immediately, releasing both lines asynchronously; no rsp_valid.

Configuration
REQ-032 With I2C_CLK_STRETCH_EN defined: quarter counter stalls while scl_o = 1 and scl_i = 0, extending the phase by stall length.
REQ-033 Without I2C_CLK_STRETCH_EN: scl_i ignored, timing fixed per REQ-024.

Structure
REQ-034 Package i2c_pkg SHALL hold opcode enum (START/WRITE/READ/STOP) and state enum (IDLE/START/WRITE/READ/STOP).
REQ-035 Sub-module i2c_qtr_tick: QTR-cycle counter with stall input and one-cycle tick output; FSM in i2c_byte_ctrl.

Verification
REQ-036 START then WRITE 0xA5, sda_i low in bit 9 -> SDA bits 1,0,1,0,0,1,0,1; rsp_valid after 36*62 cycles; rsp_nack = 0.
REQ-037 WRITE 0x3C, sda_i high in bit 9 -> rsp_nack = 1, rsp_data unchanged.
REQ-038 READ, cmd_ack = 1, slave drives 0x96 -> rsp_data = 0x96; sda_o = 1 all 9 bits.
REQ-039 STOP -> SDA rises while SCL high; 248 cycles busy; no rsp_valid pulse.
REQ-040 I2C_CLK_STRETCH_EN, scl_i low 100 cycles in WRITE bit 3 Q1 -> completion 100 cycles later (2332 total).
REQ-041 rst_n low mid-WRITE bit 5 -> scl_o = sda_o = 1 at once; cmd_ready = 1; no rsp_valid after release.
